// File: rtl/apb_rot_regs.sv
// APB3 register slave for NUM_CH rotate channels: wait-state FSM, error response,
// self-clearing control pulses and per-channel done interrupts with one aggregated IRQ.
module apb_rot_regs #(
  parameter int NUM_CH   = 2,
  parameter int WAIT_CYC = 0,
  parameter int ADDR_W   = 12
) (
  input  logic                   I_APBIF_PCLK,
  input  logic                   I_APBIF_PRESET,
  input  logic [ADDR_W-1:0]      I_APBIF_PADDR,
  input  logic [31:0]            I_APBIF_PWDATA,
  input  logic                   I_APBIF_PSEL,
  input  logic                   I_APBIF_PENABLE,
  input  logic                   I_APBIF_PWRITE,
  input  logic [NUM_CH*16-1:0]   I_APBIF_ROT_IMG_NEW_H,
  input  logic [NUM_CH*16-1:0]   I_APBIF_ROT_IMG_NEW_W,
  input  logic [NUM_CH-1:0]      I_APBIF_CH_BUSY,
  input  logic [NUM_CH-1:0]      I_APBIF_CH_DONE,
  output logic [31:0]            O_APBIF_PRDATA,
  output logic                   O_APBIF_PREADY,
  output logic                   O_APBIF_PSLVERR,
  output logic [NUM_CH*32-1:0]   O_APBIF_DMA_SRC_IMG,
  output logic [NUM_CH*32-1:0]   O_APBIF_DMA_DST_IMG,
  output logic [NUM_CH*16-1:0]   O_APBIF_ROT_IMG_H,
  output logic [NUM_CH*16-1:0]   O_APBIF_ROT_IMG_W,
  output logic [NUM_CH*2-1:0]    O_APBIF_ROT_IMG_MODE,
  output logic [NUM_CH-1:0]      O_APBIF_ROT_IMG_DIR,
  output logic [NUM_CH-1:0]      O_APBIF_CTRL_START,
  output logic [NUM_CH-1:0]      O_APBIF_CTRL_RESET,
  output logic                   O_APBIF_IRQ
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;
  logic              irq_q, irq_d;

  logic [ADDR_W-6:0] ch;
  logic [2:0]        reg_sel;
  logic [NUM_CH-1:0] ch_hit, stat_vec, mask_vec;
  logic [31:0]       rd_ch [NUM_CH];
  logic [31:0]       rdata;
  logic              busy_sel, access_err, commit, enter_done;
  logic              unused_paddr;

  assign ch           = I_APBIF_PADDR[ADDR_W-1:5];
  assign reg_sel      = I_APBIF_PADDR[4:2];
  assign unused_paddr = ^I_APBIF_PADDR[1:0];
  assign busy_sel     = |(I_APBIF_CH_BUSY & ch_hit);

  // RESET alone or with START is always accepted; a bare START is refused while busy.
  always_comb begin
    access_err = ~|ch_hit;
    if (I_APBIF_PWRITE) begin
      if (reg_sel == 3'd4) access_err = 1'b1;
      if (busy_sel && ((reg_sel < 3'd4) ||
          (reg_sel == 3'd5 && I_APBIF_PWDATA[0] && !I_APBIF_PWDATA[1])))
        access_err = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) rdata = rdata | rd_ch[i];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_APBIF_PSEL && I_APBIF_PENABLE) begin
          if (WAIT_CYC > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYC);
          end else begin
            enter_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!I_APBIF_PSEL)        state_d = S_IDLE;
        else if (cnt_q == 4'd1)   enter_done = 1'b1;
        else                      cnt_d = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (enter_done) begin
      state_d   = S_DONE;
      pslverr_d = access_err;
      prdata_d  = (access_err || I_APBIF_PWRITE) ? 32'd0 : rdata;
    end
  end

  assign commit = (state_q == S_DONE) && I_APBIF_PWRITE && !pslverr_q;
  assign irq_d  = |(stat_vec & mask_vec);

  always_ff @(posedge I_APBIF_PCLK or posedge I_APBIF_PRESET) begin
    if (I_APBIF_PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      irq_q     <= irq_d;
    end
  end

  assign O_APBIF_PRDATA  = prdata_q;
  assign O_APBIF_PSLVERR = pslverr_q;
  assign O_APBIF_PREADY  = (state_q == S_DONE);
  assign O_APBIF_IRQ     = irq_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [31:0] src_q, src_d, dst_q, dst_d, size_q, size_d, rd_val;
    logic [2:0]  cfg_q, cfg_d;
    logic        stat_q, stat_d, mask_q, mask_d;
    logic        start_q, start_d, soft_rst_q, soft_rst_d;

    assign ch_hit[gi] = (ch == (ADDR_W-5)'(gi));

    // A done pulse landing on the same edge as a W1C clear keeps the status set.
    always_comb begin
      src_d      = src_q;
      dst_d      = dst_q;
      size_d     = size_q;
      cfg_d      = cfg_q;
      stat_d     = stat_q;
      mask_d     = mask_q;
      start_d    = 1'b0;
      soft_rst_d = 1'b0;
      if (commit && ch_hit[gi]) begin
        case (reg_sel)
          3'd0: src_d  = I_APBIF_PWDATA;
          3'd1: dst_d  = I_APBIF_PWDATA;
          3'd2: size_d = I_APBIF_PWDATA;
          3'd3: cfg_d  = I_APBIF_PWDATA[2:0];
          3'd5: begin
            soft_rst_d = I_APBIF_PWDATA[1];
            start_d    = I_APBIF_PWDATA[0] & ~I_APBIF_PWDATA[1];
          end
          3'd6: if (I_APBIF_PWDATA[0]) stat_d = 1'b0;
          3'd7: mask_d = I_APBIF_PWDATA[0];
          default: ;
        endcase
      end
      if (I_APBIF_CH_DONE[gi]) stat_d = 1'b1;
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        3'd0: rd_val = src_q;
        3'd1: rd_val = dst_q;
        3'd2: rd_val = size_q;
        3'd3: rd_val = {29'd0, cfg_q};
        3'd4: rd_val = {I_APBIF_ROT_IMG_NEW_W[gi*16 +: 16], I_APBIF_ROT_IMG_NEW_H[gi*16 +: 16]};
        3'd6: rd_val = {31'd0, stat_q};
        3'd7: rd_val = {31'd0, mask_q};
        default: rd_val = '0;
      endcase
    end

    always_ff @(posedge I_APBIF_PCLK or posedge I_APBIF_PRESET) begin
      if (I_APBIF_PRESET) begin
        src_q      <= '0;
        dst_q      <= '0;
        size_q     <= '0;
        cfg_q      <= '0;
        stat_q     <= 1'b0;
        mask_q     <= 1'b0;
        start_q    <= 1'b0;
        soft_rst_q <= 1'b0;
      end else begin
        src_q      <= src_d;
        dst_q      <= dst_d;
        size_q     <= size_d;
        cfg_q      <= cfg_d;
        stat_q     <= stat_d;
        mask_q     <= mask_d;
        start_q    <= start_d;
        soft_rst_q <= soft_rst_d;
      end
    end

    assign rd_ch[gi]                        = ch_hit[gi] ? rd_val : 32'd0;
    assign stat_vec[gi]                     = stat_q;
    assign mask_vec[gi]                     = mask_q;
    assign O_APBIF_DMA_SRC_IMG[gi*32 +: 32] = src_q;
    assign O_APBIF_DMA_DST_IMG[gi*32 +: 32] = dst_q;
    assign O_APBIF_ROT_IMG_H[gi*16 +: 16]   = size_q[15:0];
    assign O_APBIF_ROT_IMG_W[gi*16 +: 16]   = size_q[31:16];
    assign O_APBIF_ROT_IMG_MODE[gi*2 +: 2]  = cfg_q[1:0];
    assign O_APBIF_ROT_IMG_DIR[gi]          = cfg_q[2];
    assign O_APBIF_CTRL_START[gi]           = start_q;
    assign O_APBIF_CTRL_RESET[gi]           = soft_rst_q;
  end
endmodule

// File: tb/tb_apb_rot_regs.sv
// Self-checking bench for apb_rot_regs: directed scenarios plus randomized APB traffic
// compared against a register-map model kept in plain arrays.
module tb_apb_rot_regs;
  localparam int NUM_CH   = 2;
  localparam int WAIT_CYC = 3;
  localparam int ADDR_W   = 12;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] paddr;
  logic [31:0] pwdata, prdata;
  logic psel, penable, pwrite, pready, pslverr, irq;
  logic [NUM_CH*16-1:0] new_h, new_w, img_h, img_w;
  logic [NUM_CH-1:0] busy, ch_done, dir, start, soft_rst;
  logic [NUM_CH*32-1:0] dma_src, dma_dst;
  logic [NUM_CH*2-1:0] mode;

  always #5 clk = ~clk;

  apb_rot_regs #(.NUM_CH(NUM_CH), .WAIT_CYC(WAIT_CYC), .ADDR_W(ADDR_W)) u_dut (
    .I_APBIF_PCLK(clk), .I_APBIF_PRESET(rst), .I_APBIF_PADDR(paddr),
    .I_APBIF_PWDATA(pwdata), .I_APBIF_PSEL(psel), .I_APBIF_PENABLE(penable),
    .I_APBIF_PWRITE(pwrite), .I_APBIF_ROT_IMG_NEW_H(new_h), .I_APBIF_ROT_IMG_NEW_W(new_w),
    .I_APBIF_CH_BUSY(busy), .I_APBIF_CH_DONE(ch_done), .O_APBIF_PRDATA(prdata),
    .O_APBIF_PREADY(pready), .O_APBIF_PSLVERR(pslverr), .O_APBIF_DMA_SRC_IMG(dma_src),
    .O_APBIF_DMA_DST_IMG(dma_dst), .O_APBIF_ROT_IMG_H(img_h), .O_APBIF_ROT_IMG_W(img_w),
    .O_APBIF_ROT_IMG_MODE(mode), .O_APBIF_ROT_IMG_DIR(dir), .O_APBIF_CTRL_START(start),
    .O_APBIF_CTRL_RESET(soft_rst), .O_APBIF_IRQ(irq)
  );

  logic [31:0] m_src [NUM_CH];
  logic [31:0] m_dst [NUM_CH];
  logic [31:0] m_size[NUM_CH];
  logic [2:0]  m_cfg [NUM_CH];
  logic        m_stat[NUM_CH];
  logic        m_mask[NUM_CH];
  int exp_start[NUM_CH], exp_rst[NUM_CH], seen_start[NUM_CH], seen_rst[NUM_CH];
  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (start[i] === 1'b1)    seen_start[i]++;
      if (soft_rst[i] === 1'b1) seen_rst[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_src[i] = '0; m_dst[i] = '0; m_size[i] = '0; m_cfg[i] = '0;
      m_stat[i] = 1'b0; m_mask[i] = 1'b0;
    end
  endtask

  task automatic model_access(input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                              input logic wr, output logic [31:0] erd, output logic eerr);
    int c, r;
    c = int'(addr[ADDR_W-1:5]);
    r = int'(addr[4:2]);
    erd = '0;
    eerr = 1'b0;
    if (c >= NUM_CH) begin eerr = 1'b1; return; end
    if (!wr) begin
      case (r)
        0: erd = m_src[c];
        1: erd = m_dst[c];
        2: erd = m_size[c];
        3: erd = {29'd0, m_cfg[c]};
        4: erd = {new_w[c*16 +: 16], new_h[c*16 +: 16]};
        6: erd = {31'd0, m_stat[c]};
        7: erd = {31'd0, m_mask[c]};
        default: erd = '0;
      endcase
      return;
    end
    if (r == 4 || (busy[c] && (r < 4 || (r == 5 && wd[0] && !wd[1])))) begin
      eerr = 1'b1;
      return;
    end
    case (r)
      0: m_src[c]  = wd;
      1: m_dst[c]  = wd;
      2: m_size[c] = wd;
      3: m_cfg[c]  = wd[2:0];
      5: begin
        if (wd[1])      exp_rst[c]++;
        else if (wd[0]) exp_start[c]++;
      end
      6: if (wd[0]) m_stat[c] = 1'b0;
      7: m_mask[c] = wd[0];
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic exp_irq;
    exp_irq = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("src%0d", i), dma_src[i*32 +: 32], m_src[i]);
      chk($sformatf("dst%0d", i), dma_dst[i*32 +: 32], m_dst[i]);
      chk($sformatf("h%0d", i), 32'(img_h[i*16 +: 16]), 32'(m_size[i][15:0]));
      chk($sformatf("w%0d", i), 32'(img_w[i*16 +: 16]), 32'(m_size[i][31:16]));
      chk($sformatf("mode%0d", i), 32'(mode[i*2 +: 2]), 32'(m_cfg[i][1:0]));
      chk($sformatf("dir%0d", i), 32'(dir[i]), 32'(m_cfg[i][2]));
      chk($sformatf("start_cyc%0d", i), seen_start[i], exp_start[i]);
      chk($sformatf("rst_cyc%0d", i), seen_rst[i], exp_rst[i]);
      exp_irq = exp_irq | (m_stat[i] & m_mask[i]);
    end
    chk("irq", 32'(irq), 32'(exp_irq));
  endtask

  // dn is raised during the PREADY cycle so it lands on the same edge as the commit.
  task automatic apb_xfer(input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input logic wr,
                          input logic [NUM_CH-1:0] dn, output logic [31:0] rd,
                          output logic err, output int cyc);
    int n;
    @(negedge clk);
    paddr = addr; pwdata = wd; pwrite = wr; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    n = 0; rd = '0; err = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (pready !== 1'b1 && n < 40);
    cyc = n + 1;
    if (pready !== 1'b1) begin
      chk("pready_timeout", 32'(pready), 32'd1);
      psel = 1'b0; penable = 1'b0;
      return;
    end
    rd = prdata; err = pslverr; ch_done = dn;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; ch_done = '0;
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic xact(input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input logic wr,
                      input logic [NUM_CH-1:0] dn);
    logic [31:0] erd, rd;
    logic eerr, err;
    int cyc;
    model_access(addr, wd, wr, erd, eerr);
    apb_xfer(addr, wd, wr, dn, rd, err, cyc);
    for (int i = 0; i < NUM_CH; i++) if (dn[i]) m_stat[i] = 1'b1;
    chk($sformatf("latency@%03h", addr), cyc, WAIT_CYC + 2);
    chk($sformatf("pslverr@%03h", addr), 32'(err), 32'(eerr));
    if (!wr) chk($sformatf("prdata@%03h", addr), rd, erd);
    $display("xact addr=%03h wr=%0d wd=%08h busy=%b done=%b rd=%08h err=%0d cyc=%0d",
             addr, wr, wd, busy, dn, rd, err, cyc);
    settle();
    check_outputs();
  endtask

  initial begin
    logic [31:0] erd, rd, wd;
    logic eerr, err, wr;
    int cyc, c, r;
    logic [NUM_CH-1:0] dn;

    paddr = '0; pwdata = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    busy = '0; ch_done = '0; new_h = '0; new_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_start[i] = 0; exp_rst[i] = 0; seen_start[i] = 0; seen_rst[i] = 0;
    end
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    check_outputs();
    rst = 1'b0;

    // Source register write and read-back on channel 0.
    xact(12'h000, 32'h1234_5678, 1'b1, '0);
    chk("src0_direct", dma_src[31:0], 32'h1234_5678);
    xact(12'h000, 32'h0, 1'b0, '0);

    // Size on channel 1.
    xact(12'h028, 32'h0200_0100, 1'b1, '0);
    chk("h1_direct", 32'(img_h[31:16]), 32'h0100);
    chk("w1_direct", 32'(img_w[31:16]), 32'h0200);

    // Busy lockout; soft reset still accepted.
    busy = 2'b01;
    xact(12'h00C, 32'h7, 1'b1, '0);
    xact(12'h014, 32'h1, 1'b1, '0);
    chk("cfg0_locked", 32'(mode[1:0]), 32'd0);
    xact(12'h014, 32'h2, 1'b1, '0);
    chk("rst0_single", seen_rst[0], 1);
    busy = '0;

    // NEW_SIZE is read-only, out-of-range channel errors.
    xact(12'h010, 32'hFFFF_FFFF, 1'b1, '0);
    xact(12'h040, 32'h0, 1'b0, '0);
    new_h[15:0] = 16'h0080;
    new_w[15:0] = 16'h0040;
    model_access(12'h010, 32'h0, 1'b0, erd, eerr);
    chk("newsize_model", erd, 32'h0040_0080);
    xact(12'h010, 32'h0, 1'b0, '0);

    // Interrupt: set, set-beats-clear, then clear with one-cycle IRQ latency.
    xact(12'h03C, 32'h1, 1'b1, '0);
    @(negedge clk); ch_done = 2'b10;
    @(negedge clk); ch_done = '0;
    #1 chk("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    #1 chk("irq_set", 32'(irq), 32'd1);
    m_stat[1] = 1'b1;
    xact(12'h038, 32'h1, 1'b1, 2'b10);
    xact(12'h038, 32'h0, 1'b0, '0);
    model_access(12'h038, 32'h1, 1'b1, erd, eerr);
    apb_xfer(12'h038, 32'h1, 1'b1, '0, rd, err, cyc);
    chk("w1c_err", 32'(err), 32'(eerr));
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk);
    #1 chk("irq_clr", 32'(irq), 32'd0);
    settle();
    check_outputs();

    // Asynchronous reset while the FSM is inserting wait states.
    @(negedge clk);
    paddr = 12'h004; pwdata = 32'hDEAD_BEEF; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pready", 32'(pready), 32'd0);
    chk("mid_rst_src0", dma_src[31:0], 32'd0);
    chk("mid_rst_h1", 32'(img_h[31:16]), 32'd0);
    model_reset();
    @(negedge clk);
    chk("mid_rst_dst0", dma_dst[31:0], 32'd0);
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    settle();
    check_outputs();
    xact(12'h004, 32'hCAFE_F00D, 1'b1, '0);
    xact(12'h004, 32'h0, 1'b0, '0);

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      c = $urandom_range(0, NUM_CH);
      if (c == NUM_CH && $urandom_range(0, 1) == 1) c = 127;
      r = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      busy = NUM_CH'($urandom);
      if (c < NUM_CH && busy[c] && r == 5 && wd[1:0] == 2'b11) wd[0] = 1'b0;
      dn = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        new_h[i*16 +: 16] = 16'($urandom);
        new_w[i*16 +: 16] = 16'($urandom);
      end
      xact({7'(c), 3'(r), 2'b00}, wd, wr, dn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
